// File: rtl/kbd_pkg.sv
// kbd_pkg: shared constants and FSM encoding for the PS/2 scan-code tracker.
//   - Protocol bytes: break prefix (F0), extended prefix (E0) and the
//     keyboard status bytes that carry no key information (AA, FA, EE).
//   - Default make codes for left/right Shift and CapsLock.
//   - Decoder state encoding kbd_state_e.
package kbd_pkg;

  localparam logic [7:0] SC_BRK  = 8'hF0;  // break (release) prefix
  localparam logic [7:0] SC_EXT  = 8'hE0;  // extended-key prefix
  localparam logic [7:0] SC_BAT  = 8'hAA;  // self-test passed
  localparam logic [7:0] SC_ACK  = 8'hFA;  // command acknowledge
  localparam logic [7:0] SC_ECHO = 8'hEE;  // echo response

  localparam logic [7:0] SC_LSHFT_DEF = 8'h12;
  localparam logic [7:0] SC_RSHFT_DEF = 8'h59;
  localparam logic [7:0] SC_CAPS_DEF  = 8'h58;
  localparam int         COUNT_W_DEF  = 8;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,  // no prefix pending
    S_EXT     = 2'd1,  // E0 seen
    S_BRK     = 2'd2,  // F0 seen
    S_EXT_BRK = 2'd3   // E0 F0 seen
  } kbd_state_e;

  // Status bytes the keyboard sends outside of key sequences.
  function automatic logic is_status_byte(input logic [7:0] b);
    return (b == SC_BAT) || (b == SC_ACK) || (b == SC_ECHO);
  endfunction

endpackage

// File: rtl/kbd_byte_fetch.sv
// kbd_byte_fetch: pops one byte at a time from the PS/2 receiver FIFO.
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   ps2_ready_i         FIFO non-empty (ps2_data_i valid)
//   ps2_data_i[7:0]     byte at the FIFO head
//   ps2_nextdata_o      registered 1-cycle pop strobe to the FIFO
//   byte_vld_o          1 in the cycle the latched byte is to be decoded
//   byte_data_o[7:0]    latched byte
//
// Handshake: a byte is taken when ps2_ready_i=1 while ps2_nextdata_o=0. The
// byte is latched and ps2_nextdata_o is raised for exactly the next cycle,
// which pops the FIFO at the following edge. ready is ignored while the pop
// strobe is high, so the FIFO head is never sampled before it has advanced;
// this limits the fetch rate to one byte every two cycles.
module kbd_byte_fetch (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ps2_ready_i,
  input  logic [7:0] ps2_data_i,
  output logic       ps2_nextdata_o,
  output logic       byte_vld_o,
  output logic [7:0] byte_data_o
);

  logic       nextdata_q, nextdata_d;
  logic [7:0] data_q, data_d;

  always_comb begin
    nextdata_d = 1'b0;
    data_d     = data_q;
    if (ps2_ready_i && !nextdata_q) begin
      nextdata_d = 1'b1;
      data_d     = ps2_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      nextdata_q <= 1'b0;
      data_q     <= 8'h00;
    end else begin
      nextdata_q <= nextdata_d;
      data_q     <= data_d;
    end
  end

  // The pop-strobe cycle is also the decode cycle of the latched byte.
  assign ps2_nextdata_o = nextdata_q;
  assign byte_vld_o     = nextdata_q;
  assign byte_data_o    = data_q;

endmodule

// File: rtl/kbd_scan_tracker.sv
// kbd_scan_tracker: decodes PS/2 set-2 scan-code sequences (make, F0 break,
// E0 extended) into current key, held state, Shift/CapsLock flags and a
// key-press counter.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   ps2_ready, ps2_data  receiver FIFO non-empty / head byte
//   ps2_nextdata         1-cycle pop strobe to the FIFO
//   key_code[7:0]        last non-modifier make code
//   key_valid            key_code currently held
//   key_press            1-cycle pulse per counted make
//   extended             key_code was E0-prefixed
//   shift                either Shift held
//   capital              CapsLock toggle state
//   press_count          counted presses, wraps modulo 2**COUNT_W
// Build option: AUTOREPEAT_FILTER_EN suppresses key_press/count for a
//   typematic repeat (make of the held key_code, same extended flag).
module kbd_scan_tracker
  import kbd_pkg::*;
#(
  parameter int         COUNT_W  = COUNT_W_DEF,
  parameter logic [7:0] SC_LSHFT = SC_LSHFT_DEF,
  parameter logic [7:0] SC_RSHFT = SC_RSHFT_DEF,
  parameter logic [7:0] SC_CAPS  = SC_CAPS_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ps2_ready,
  input  logic [7:0]         ps2_data,
  output logic               ps2_nextdata,
  output logic [7:0]         key_code,
  output logic               key_valid,
  output logic               key_press,
  output logic               extended,
  output logic               shift,
  output logic               capital,
  output logic [COUNT_W-1:0] press_count
);

  logic       byte_vld;
  logic [7:0] byte_data;

  kbd_byte_fetch u_fetch (
    .clk_i          (clk),
    .rst_i          (rst),
    .ps2_ready_i    (ps2_ready),
    .ps2_data_i     (ps2_data),
    .ps2_nextdata_o (ps2_nextdata),
    .byte_vld_o     (byte_vld),
    .byte_data_o    (byte_data)
  );

  kbd_state_e         state_q, state_d;
  logic [7:0]         key_code_q, key_code_d;
  logic               key_valid_q, key_valid_d;
  logic               key_press_q, key_press_d;
  logic               extended_q, extended_d;
  logic               lshift_q, lshift_d;
  logic               rshift_q, rshift_d;
  logic               caps_held_q, caps_held_d;
  logic               capital_q, capital_d;
  logic [COUNT_W-1:0] count_q, count_d;

  logic do_make;   // terminal byte of a make sequence
  logic do_brk;    // terminal byte of a break sequence
  logic seq_ext;   // current sequence carried an E0 prefix
  logic count_en;  // this make is counted

  assign seq_ext = (state_q == S_EXT) || (state_q == S_EXT_BRK);

`ifdef AUTOREPEAT_FILTER_EN
  logic is_repeat;
  assign is_repeat = key_valid_q && (byte_data == key_code_q) && (extended_q == seq_ext);
  assign count_en  = !is_repeat;
`else
  assign count_en  = 1'b1;
`endif

  // Sequence decoder: prefixes move between states, the first non-prefix
  // byte terminates the sequence and returns to S_IDLE.
  always_comb begin
    state_d = state_q;
    do_make = 1'b0;
    do_brk  = 1'b0;
    if (byte_vld) begin
      unique case (state_q)
        S_IDLE: begin
          if (byte_data == SC_EXT)      state_d = S_EXT;
          else if (byte_data == SC_BRK) state_d = S_BRK;
          else if (!is_status_byte(byte_data)) do_make = 1'b1;
        end
        S_EXT: begin
          if (byte_data == SC_BRK) state_d = S_EXT_BRK;
          else if (byte_data != SC_EXT) begin
            do_make = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_BRK, S_EXT_BRK: begin
          if ((byte_data != SC_EXT) && (byte_data != SC_BRK)) begin
            do_brk  = 1'b1;
            state_d = S_IDLE;
          end
        end
      endcase
    end
  end

  // Key and modifier bookkeeping driven by completed sequences.
  always_comb begin
    key_code_d  = key_code_q;
    key_valid_d = key_valid_q;
    key_press_d = 1'b0;
    extended_d  = extended_q;
    lshift_d    = lshift_q;
    rshift_d    = rshift_q;
    caps_held_d = caps_held_q;
    capital_d   = capital_q;
    count_d     = count_q;

    if (do_make) begin
      if (byte_data == SC_LSHFT) begin
        lshift_d = 1'b1;
      end else if (byte_data == SC_RSHFT) begin
        rshift_d = 1'b1;
      end else if (byte_data == SC_CAPS) begin
        // Only the first make of a hold toggles; typematic repeats do not.
        if (!caps_held_q) capital_d = !capital_q;
        caps_held_d = 1'b1;
      end else begin
        key_code_d  = byte_data;
        extended_d  = seq_ext;
        key_valid_d = 1'b1;
        if (count_en) begin
          key_press_d = 1'b1;
          count_d     = count_q + COUNT_W'(1);
        end
      end
    end

    if (do_brk) begin
      if (byte_data == SC_LSHFT) begin
        lshift_d = 1'b0;
      end else if (byte_data == SC_RSHFT) begin
        rshift_d = 1'b0;
      end else if (byte_data == SC_CAPS) begin
        caps_held_d = 1'b0;
      end else if ((byte_data == key_code_q) && (seq_ext == extended_q)) begin
        // Release of an earlier, rolled-over key leaves key_valid alone.
        key_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      key_code_q  <= 8'h00;
      key_valid_q <= 1'b0;
      key_press_q <= 1'b0;
      extended_q  <= 1'b0;
      lshift_q    <= 1'b0;
      rshift_q    <= 1'b0;
      caps_held_q <= 1'b0;
      capital_q   <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_press_q <= key_press_d;
      extended_q  <= extended_d;
      lshift_q    <= lshift_d;
      rshift_q    <= rshift_d;
      caps_held_q <= caps_held_d;
      capital_q   <= capital_d;
      count_q     <= count_d;
    end
  end

  assign key_code    = key_code_q;
  assign key_valid   = key_valid_q;
  assign key_press   = key_press_q;
  assign extended    = extended_q;
  assign shift       = lshift_q | rshift_q;
  assign capital     = capital_q;
  assign press_count = count_q;

endmodule
